// File: rtl/barrel_shifter_pkg.sv
// Shared encodings for the barrel shifter: operation modes and shift direction.
package barrel_shifter_pkg;

  localparam logic [1:0] MODE_LOGICAL  = 2'b00;
  localparam logic [1:0] MODE_ROTATE   = 2'b01;
  localparam logic [1:0] MODE_ARITH    = 2'b10;
  localparam logic [1:0] MODE_RESERVED = 2'b11;  // decodes as logical

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage : barrel_shifter_pkg

// File: rtl/barrel_stage.sv
// One mux stage of the shifter: left shift/rotate by a fixed amount when enabled.
module barrel_stage #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (rotate) begin
      shifted = {data_i[WIDTH-1-SHIFT:0], data_i[WIDTH-1:WIDTH-SHIFT]};
    end else begin
      shifted = {data_i[WIDTH-1-SHIFT:0], {SHIFT{fill}}};
    end
    data_o = en ? shifted : data_i;
  end

endmodule : barrel_stage

// File: rtl/barrel_shifter.sv
// Registered barrel shifter: right shifts reuse the left-shift network via bit reversal.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   n,
  input  logic             Lr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid
);

  logic [WIDTH-1:0] pre_shift;
  logic [WIDTH-1:0] result;
  logic             rotate;
  logic             fill_bit;
  logic [WIDTH-1:0] stage_data [SHW+1];

  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;

  // Arithmetic fill only matters going right; after reversal the original MSB
  // lands at the LSB end, which is exactly where the left network fills.
  always_comb begin
    rotate   = (mode == MODE_ROTATE);
    fill_bit = (mode == MODE_ARITH) && (Lr == DIR_RIGHT) && In[WIDTH-1];
    for (int i = 0; i < WIDTH; i++) begin
      pre_shift[i] = (Lr == DIR_LEFT) ? In[i] : In[WIDTH-1-i];
    end
  end

  assign stage_data[0] = pre_shift;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .data_i (stage_data[k]),
      .en     (n[k]),
      .rotate (rotate),
      .fill   (fill_bit),
      .data_o (stage_data[k+1])
    );
  end

  // NOTE: every variable written here gets a value on every path (Out holds
  // via an explicit out_q term), so no latch is inferred.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = (Lr == DIR_LEFT) ? stage_data[SHW][i] : stage_data[SHW][WIDTH-1-i];
    end
    out_d       = in_valid ? result : out_q;
    out_valid_d = in_valid;
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Out       = out_q;
  assign out_valid = out_valid_q;

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Directed self-checking bench for barrel_shifter (WIDTH = 8).
module tb_barrel_shifter;
  import barrel_shifter_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [2:0]   n;
  logic         lr;
  logic [1:0]   mode;
  logic [W-1:0] out_data;
  logic         out_valid;

  int checks   = 0;
  int failures = 0;

  barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .In        (in_data),
    .n         (n),
    .Lr        (lr),
    .mode      (mode),
    .Out       (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand, clock it in, then check result and valid 1 ns after the edge.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [2:0] amt,
                    input logic dir, input logic [1:0] md, input logic [W-1:0] exp);
    in_valid = 1'b1;
    in_data  = a;
    n        = amt;
    lr       = dir;
    mode     = md;
    @(posedge clk);
    #1;
    check({tag, "_out"}, out_data, exp);
    check({tag, "_vld"}, {7'b0, out_valid}, 8'h01);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    n        = '0;
    lr       = 1'b0;
    mode     = MODE_LOGICAL;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out_data, 8'h00);
    check("rst_vld", {7'b0, out_valid}, 8'h00);
    rst_n = 1'b1;

    op("lsl1",  8'hAA, 3'd1, DIR_LEFT,  MODE_LOGICAL, 8'h54);
    op("lsr1",  8'hAA, 3'd1, DIR_RIGHT, MODE_LOGICAL, 8'h55);
    op("lsr2",  8'hAA, 3'd2, DIR_RIGHT, MODE_LOGICAL, 8'h2A);

    op("rol1",  8'hAA, 3'd1, DIR_LEFT,  MODE_ROTATE,  8'h55);
    op("ror3",  8'hAA, 3'd3, DIR_RIGHT, MODE_ROTATE,  8'h55);
    op("rol7",  8'h81, 3'd7, DIR_LEFT,  MODE_ROTATE,  8'hC0);

    op("asr2n", 8'hAA, 3'd2, DIR_RIGHT, MODE_ARITH,   8'hEA);
    op("asr2p", 8'h6A, 3'd2, DIR_RIGHT, MODE_ARITH,   8'h1A);
    op("asl1",  8'hAA, 3'd1, DIR_LEFT,  MODE_ARITH,   8'h54);
    op("asr7",  8'h80, 3'd7, DIR_RIGHT, MODE_ARITH,   8'hFF);

    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 2; d++) begin
        op($sformatf("pass_m%0d_d%0d", m, d), 8'hC3, 3'd0, d[0], m[1:0], 8'hC3);
      end
    end

    op("resv_r1", 8'hAA, 3'd1, DIR_RIGHT, MODE_RESERVED, 8'h55);
    op("resv_l3", 8'h81, 3'd3, DIR_LEFT,  MODE_RESERVED, 8'h08);

    // Four back-to-back operands (in_valid never drops), then one idle cycle.
    op("b2b0", 8'h0F, 3'd4, DIR_LEFT,  MODE_LOGICAL, 8'hF0);
    op("b2b1", 8'h0F, 3'd4, DIR_LEFT,  MODE_ROTATE,  8'hF0);
    op("b2b2", 8'hF0, 3'd5, DIR_RIGHT, MODE_ROTATE,  8'h87);
    op("b2b3", 8'h90, 3'd3, DIR_RIGHT, MODE_ARITH,   8'hF2);
    in_valid = 1'b0;
    in_data  = 8'h55;
    @(posedge clk);
    #1;
    check("idle_vld",  {7'b0, out_valid}, 8'h00);
    check("idle_hold", out_data, 8'hF2);

    // Asynchronous reset mid-cycle with a nonzero held result.
    op("pre_rst", 8'h3C, 3'd1, DIR_LEFT, MODE_LOGICAL, 8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out_data, 8'h00);
    check("async_rst_vld", {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold_out", out_data, 8'h00);
    rst_n = 1'b1;
    op("post_rst", 8'h01, 3'd7, DIR_LEFT, MODE_LOGICAL, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_barrel_shifter

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Registered, parameterised barrel shifter for the datapath.
- Shifts or rotates a WIDTH-bit operand left or right by 0..WIDTH-1 positions in one clock.
- Built as a log2(WIDTH)-stage mux network; only the output is registered.
- Used by ALU-style blocks that need variable shifts with a single-cycle, valid-tagged result.

Parameters:
- WIDTH, 8, operand width in bits; must be a power of 2 and at least 2.
- SHW, $clog2(WIDTH) (3 by default), width of the shift-amount port; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies In/n/Lr/mode this cycle
- In  input  WIDTH  operand
- n  input  SHW  shift amount, 0..WIDTH-1
- Lr  input  1  direction: 1 = left, 0 = right
- mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical)
- Out  output  WIDTH  registered result
- out_valid  output  1  Out holds a result from the previous in_valid cycle

Behaviour:
- Reset (rst_n low, asynchronous): Out = 0 and out_valid = 0 immediately; both are held while rst_n is low.
- Latency is exactly 1 cycle. On a clk rise with in_valid = 1, Out <= f(In, n, Lr, mode) and out_valid <= 1.
- On a clk rise with in_valid = 0: out_valid <= 0 and Out holds its previous value.
- There is no back-pressure. A new operand can be accepted every cycle (throughput 1/cycle).
- Logical left: Out = In << n, zero fill from the LSB.
- Logical right: Out = In >> n, zero fill from the MSB.
- Rotate left: bits shifted out of the MSB re-enter at the LSB. Rotate right is the mirror.
- Arithmetic right: vacated MSBs are filled with In[WIDTH-1].
- Arithmetic left behaves the same as logical left.
- mode 11 behaves exactly as mode 00.
- n = 0 passes In through unchanged in every mode and direction.
- n is at most WIDTH-1 by port width, so an out-of-range amount cannot occur.
- Combinational core:
  - SHW cascaded stages; stage k shifts by 2^k when n[k] = 1.
  - Right shifts are implemented by bit-reversing the input, left-shifting, then bit-reversing the result. The arithmetic fill bit is the original MSB.
- When rst_n deasserts, the first accepted operand is captured on the first subsequent clk rise.
- Asserting rst_n mid-stream discards any in-flight result.

Decomposition:
- Shared package: mode encodings as named constants (MODE_LOGICAL = 2'b00, MODE_ROTATE = 2'b01, MODE_ARITH = 2'b10) and direction constants (DIR_LEFT = 1, DIR_RIGHT = 0).
- Sub-module barrel_stage, instantiated SHW times:
  - Parameters: WIDTH and a fixed shift amount.
  - Inputs: data, an enable bit, a rotate flag and a fill bit.
  - Output: the data shifted left by the fixed amount when enabled, otherwise passed through.
- The top level handles bit reversal, fill selection, the output register and the valid pipeline.

Test Plan:
- Reset: drive rst_n low mid-cycle with Out nonzero -> Out = 0x00 and out_valid = 0 without waiting for a clk edge.
- Logical, WIDTH = 8, In = 0xAA:
  - n = 1, Lr = 1 -> Out = 0x54.
  - n = 1, Lr = 0 -> Out = 0x55.
  - n = 2, Lr = 0 -> Out = 0x2A.
  - Each result appears one cycle after in_valid, with out_valid = 1.
- Rotate, In = 0xAA:
  - n = 1, Lr = 1 -> 0x55.
  - n = 3, Lr = 0 -> 0x55.
  - In = 0x81, n = 7, Lr = 1 -> 0xC0.
- Arithmetic right:
  - In = 0xAA, n = 2 -> 0xEA.
  - In = 0x6A, n = 2 -> 0x1A.
  - Arithmetic left with In = 0xAA, n = 1 -> 0x54.
- Pass-through and reserved mode:
  - n = 0 with every mode/Lr combination, In = 0xC3 -> Out = 0xC3.
  - mode = 11 with In = 0xAA, n = 1, Lr = 0 -> 0x55.
- Throughput and valid: back-to-back in_valid for 4 cycles, then one idle cycle -> four consecutive correct results, then out_valid = 0 with Out held at the last value.
